// File: rtl/dsp_pack_scheduler_if.sv
// Request, DSP-drive and result bundle between two requesters, the scheduler and the DSP.
// The slave modport is the scheduler's view; master is the surrounding logic.
interface dsp_pack_scheduler_if #(
    parameter int N = 9,
    parameter int M = 9
);
    logic [1:0]     req_valid;
    logic [1:0]     req_ready;
    logic [N-1:0]   req_a0, req_a1;
    logic [M-1:0]   req_b0, req_b1;
    logic           dsp_start;
    logic [1:0]     dsp_mode;
    logic [N-1:0]   dsp_aa;
    logic [M-1:0]   dsp_bb;
    logic [N+M-1:0] dsp_out;
    logic [1:0]     res_valid;
    logic [N+M-1:0] res_data0, res_data1;

    modport slave (
        input  req_valid, req_a0, req_b0, req_a1, req_b1, dsp_out,
        output req_ready, dsp_start, dsp_mode, dsp_aa, dsp_bb,
               res_valid, res_data0, res_data1
    );

    modport master (
        output req_valid, req_a0, req_b0, req_a1, req_b1, dsp_out,
        input  req_ready, dsp_start, dsp_mode, dsp_aa, dsp_bb,
               res_valid, res_data0, res_data1
    );
endinterface

// File: rtl/dsp_pack_scheduler.sv
// Shares one fracturable 9x9 DSP between two requesters: packs two narrow ops into
// dual-lane mode, otherwise issues full-width ops round-robin; a tag pipeline routes products back.
module dsp_pack_scheduler #(
    parameter int N       = 9,
    parameter int M       = 9,
    parameter int DSP_LAT = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                pack_en,
    dsp_pack_scheduler_if.slave bus
);
    localparam int W = N + M;

    logic               rr, gnt, pack, issue;
    logic [1:0]         narrow, ready;
    logic [4:0]         a_l0, b_l0;
    logic [3:0]         a_l1, b_l1;
    logic [N-1:0]       aa_nxt, aa_q;
    logic [M-1:0]       bb_nxt, bb_q;
    logic [1:0]         mode_q;
    logic [DSP_LAT:0]   vld_pipe, pk_pipe, own_pipe;
    logic [1:0]         res_valid_q;
    logic [W-1:0]       res0_q, res1_q, lane0, lane1;

    assign narrow[0] = (bus.req_a0[N-1:4] == '0) && (bus.req_b0[M-1:4] == '0);
    assign narrow[1] = (bus.req_a1[N-1:4] == '0) && (bus.req_b1[M-1:4] == '0);
    assign pack      = pack_en && (&bus.req_valid) && (&narrow);
    assign issue     = |bus.req_valid;

    // gnt is the full-issue winner; on a packed issue it stays at rr (the lane-0 owner)
    always_comb begin
        ready = 2'b00;
        gnt   = rr;
        if (pack) begin
            ready = 2'b11;
        end else if (bus.req_valid[rr]) begin
            ready[rr] = 1'b1;
        end else if (bus.req_valid[~rr]) begin
            ready[~rr] = 1'b1;
            gnt        = ~rr;
        end
    end
    assign bus.req_ready = ready;

    assign a_l0 = rr ? bus.req_a1[4:0] : bus.req_a0[4:0];
    assign b_l0 = rr ? bus.req_b1[4:0] : bus.req_b0[4:0];
    assign a_l1 = rr ? bus.req_a0[3:0] : bus.req_a1[3:0];
    assign b_l1 = rr ? bus.req_b0[3:0] : bus.req_b1[3:0];

    always_comb begin
        aa_nxt = gnt ? bus.req_a1 : bus.req_a0;
        bb_nxt = gnt ? bus.req_b1 : bus.req_b0;
        if (pack) begin
            aa_nxt      = '0;
            bb_nxt      = '0;
            aa_nxt[4:0] = a_l0;
            aa_nxt[8:5] = a_l1;
            bb_nxt[4:0] = b_l0;
            bb_nxt[8:5] = b_l1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr     <= 1'b0;
            mode_q <= 2'b00;
            aa_q   <= '0;
            bb_q   <= '0;
        end else if (issue) begin
            mode_q <= pack ? 2'b01 : 2'b00;
            aa_q   <= aa_nxt;
            bb_q   <= bb_nxt;
            if (!pack) rr <= ~gnt;
        end
    end

    // stage 0 rides alongside dsp_start; stage DSP_LAT lines up with dsp_out
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            pk_pipe  <= '0;
            own_pipe <= '0;
        end else begin
            vld_pipe <= {vld_pipe[DSP_LAT-1:0], issue};
            pk_pipe  <= {pk_pipe[DSP_LAT-1:0], pack};
            own_pipe <= {own_pipe[DSP_LAT-1:0], gnt};
        end
    end

    assign bus.dsp_start = vld_pipe[0];
    assign bus.dsp_mode  = mode_q;
    assign bus.dsp_aa    = aa_q;
    assign bus.dsp_bb    = bb_q;

    always_comb begin
        lane0       = '0;
        lane1       = '0;
        lane0[9:0]  = bus.dsp_out[9:0];
        lane1[7:0]  = bus.dsp_out[17:10];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid_q <= 2'b00;
            res0_q      <= '0;
            res1_q      <= '0;
        end else begin
            res_valid_q <= 2'b00;
            if (vld_pipe[DSP_LAT]) begin
                if (pk_pipe[DSP_LAT]) begin
                    res_valid_q <= 2'b11;
                    if (own_pipe[DSP_LAT]) begin
                        res1_q <= lane0;
                        res0_q <= lane1;
                    end else begin
                        res0_q <= lane0;
                        res1_q <= lane1;
                    end
                end else begin
                    res_valid_q[own_pipe[DSP_LAT]] <= 1'b1;
                    if (own_pipe[DSP_LAT]) res1_q <= bus.dsp_out;
                    else                   res0_q <= bus.dsp_out;
                end
            end
        end
    end

    assign bus.res_valid = res_valid_q;
    assign bus.res_data0 = res0_q;
    assign bus.res_data1 = res1_q;
endmodule

// File: tb/tb_dsp_pack_scheduler.sv
// Drives two schedulers (DSP_LAT 1 and 4) with identical requests; each has a behavioural
// fracturable DSP behind it. Directed vectors plus a scoreboard of expected results per cycle.
module tb_dsp_pack_scheduler;
    localparam int N  = 9;
    localparam int M  = 9;
    localparam int W  = N + M;
    localparam int LA = 1;
    localparam int LB = 4;

    logic         clk = 1'b0, rst_n = 1'b0, pack_en = 1'b0;
    logic [1:0]   v = 2'b00, g = 2'b00;
    logic [N-1:0] ra0 = '0, ra1 = '0;
    logic [M-1:0] rb0 = '0, rb1 = '0;
    int           n_cmp = 0, n_bad = 0, cyc = 0, n_ops = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dsp_pack_scheduler_if #(.N(N), .M(M)) ia ();
    dsp_pack_scheduler_if #(.N(N), .M(M)) ib ();

    assign ia.req_valid = v;  assign ib.req_valid = v;
    assign ia.req_a0 = ra0;   assign ib.req_a0 = ra0;
    assign ia.req_b0 = rb0;   assign ib.req_b0 = rb0;
    assign ia.req_a1 = ra1;   assign ib.req_a1 = ra1;
    assign ia.req_b1 = rb1;   assign ib.req_b1 = rb1;

    dsp_pack_scheduler #(.N(N), .M(M), .DSP_LAT(LA)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .pack_en(pack_en), .bus(ia));
    dsp_pack_scheduler #(.N(N), .M(M), .DSP_LAT(LB)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .pack_en(pack_en), .bus(ib));

    function automatic logic [W-1:0] dsp_fn(logic [1:0] md, logic [N-1:0] x, logic [M-1:0] y);
        logic [9:0] p0;
        logic [7:0] p1;
        p0 = {5'd0, x[4:0]} * {5'd0, y[4:0]};
        p1 = {4'd0, x[8:5]} * {4'd0, y[8:5]};
        if (md == 2'b01) return {p1, p0};
        return {9'd0, x} * {9'd0, y};
    endfunction

    logic [W-1:0] pa [LA];
    logic [W-1:0] pb [LB];
    always @(posedge clk) begin
        pa[0] <= dsp_fn(ia.dsp_mode, ia.dsp_aa, ia.dsp_bb);
        for (int k = 1; k < LA; k++) pa[k] <= pa[k-1];
        pb[0] <= dsp_fn(ib.dsp_mode, ib.dsp_aa, ib.dsp_bb);
        for (int k = 1; k < LB; k++) pb[k] <= pb[k-1];
    end
    assign ia.dsp_out = pa[LA-1];
    assign ib.dsp_out = pb[LB-1];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [1:0]   rv [2], md [2];
    logic         st [2];
    logic [W-1:0] rd0 [2], rd1 [2];
    logic [N-1:0] oaa [2];
    logic [M-1:0] obb [2];
    assign rv[0] = ia.res_valid;  assign rv[1] = ib.res_valid;
    assign rd0[0] = ia.res_data0; assign rd0[1] = ib.res_data0;
    assign rd1[0] = ia.res_data1; assign rd1[1] = ib.res_data1;
    assign st[0] = ia.dsp_start;  assign st[1] = ib.dsp_start;
    assign md[0] = ia.dsp_mode;   assign md[1] = ib.dsp_mode;
    assign oaa[0] = ia.dsp_aa;    assign oaa[1] = ib.dsp_aa;
    assign obb[0] = ia.dsp_bb;    assign obb[1] = ib.dsp_bb;

    // reference model: expected result strobes/data indexed by due cycle
    logic       m_rr = 1'b0;
    logic [1:0] ev [2][64];
    int         ed0 [2][64], ed1 [2][64];
    int         exp_cnt [2], got_cnt [2];

    initial begin
        for (int d = 0; d < 2; d++) begin
            exp_cnt[d] = 0;
            got_cnt[d] = 0;
            for (int k = 0; k < 64; k++) ev[d][k] = 2'b00;
        end
    end

    always @(negedge clk) begin
        logic [1:0] er;
        logic       pk, gw;
        int         x0, y0, x1, y1, s, sl;
        if (!rst_n) begin
            m_rr = 1'b0;
            for (int d = 0; d < 2; d++) begin
                for (int k = 0; k < 64; k++) ev[d][k] = 2'b00;
                chk("rst_start", 32'(st[d]), 0);
                chk("rst_mode", 32'(md[d]), 0);
                chk("rst_aa", 32'(oaa[d]), 0);
                chk("rst_bb", 32'(obb[d]), 0);
                chk("rst_resv", 32'(rv[d]), 0);
                chk("rst_rd0", 32'(rd0[d]), 0);
                chk("rst_rd1", 32'(rd1[d]), 0);
            end
        end else begin
            x0 = int'(ra0); y0 = int'(rb0); x1 = int'(ra1); y1 = int'(rb1);
            pk = pack_en && (v == 2'b11) && x0 < 16 && y0 < 16 && x1 < 16 && y1 < 16;
            er = 2'b00;
            gw = m_rr;
            if (pk) er = 2'b11;
            else if (v[m_rr]) er[m_rr] = 1'b1;
            else if (v[!m_rr]) begin er[!m_rr] = 1'b1; gw = !m_rr; end
            chk("rdy_a", 32'(ia.req_ready), 32'(er));
            chk("rdy_b", 32'(ib.req_ready), 32'(er));
            sl = cyc % 64;
            for (int d = 0; d < 2; d++) begin
                chk("res_valid", 32'(rv[d]), 32'(ev[d][sl]));
                if (ev[d][sl][0]) chk("res_data0", 32'(rd0[d]), ed0[d][sl]);
                if (ev[d][sl][1]) chk("res_data1", 32'(rd1[d]), ed1[d][sl]);
                got_cnt[d] += $countones(rv[d]);
                ev[d][sl] = 2'b00;
            end
            if (er != 2'b00) begin
                for (int d = 0; d < 2; d++) begin
                    s = (cyc + (d == 1 ? LB : LA) + 2) % 64;
                    ev[d][s] = er;
                    if (pk) begin
                        ed0[d][s] = x0 * y0;
                        ed1[d][s] = x1 * y1;
                        exp_cnt[d] += 2;
                    end else begin
                        if (gw) ed1[d][s] = x1 * y1;
                        else    ed0[d][s] = x0 * y0;
                        exp_cnt[d] += 1;
                    end
                end
                if (!pk) m_rr = !gw;
            end
        end
    end

    initial begin
        tick(2);
        rst_n = 1'b1;
        tick(1);

        // full single
        v = 2'b01; ra0 = 300; rb0 = 200; #1;
        chk("full_rdy", 32'(ia.req_ready), 2'b01);
        tick; v = 2'b00;
        chk("full_start", 32'(ia.dsp_start), 1);
        chk("full_mode", 32'(ia.dsp_mode), 0);
        chk("full_aa", 32'(ia.dsp_aa), 300);
        tick(2);
        chk("full_rv_a", 32'(ia.res_valid), 2'b01);
        chk("full_rd_a", 32'(ia.res_data0), 60000);
        chk("idle_hold_aa", 32'(ia.dsp_aa), 300);
        chk("idle_start", 32'(ia.dsp_start), 0);
        tick;
        chk("full_pulse", 32'(ia.res_valid), 0);
        tick(2);
        chk("full_rv_b", 32'(ib.res_valid), 2'b01);
        chk("full_rd_b", 32'(ib.res_data0), 60000);

        // serve requester 1 alone so the pointer returns to 0
        v = 2'b10; ra1 = 5; rb1 = 6; #1;
        chk("rr_fix_rdy", 32'(ia.req_ready), 2'b10);
        tick; v = 2'b00;
        tick(8);

        // packed pair
        pack_en = 1'b1; v = 2'b11; ra0 = 7; rb0 = 9; ra1 = 15; rb1 = 15; #1;
        chk("pack_rdy", 32'(ia.req_ready), 2'b11);
        tick; v = 2'b00;
        chk("pack_start", 32'(ia.dsp_start), 1);
        chk("pack_mode", 32'(ia.dsp_mode), 2'b01);
        chk("pack_aa", 32'(ia.dsp_aa), 32'h1E7);
        chk("pack_bb", 32'(ia.dsp_bb), 32'h1E9);
        tick(2);
        chk("pack_rv_a", 32'(ia.res_valid), 2'b11);
        chk("pack_rd0_a", 32'(ia.res_data0), 63);
        chk("pack_rd1_a", 32'(ia.res_data1), 225);
        tick(3);
        chk("pack_rv_b", 32'(ib.res_valid), 2'b11);
        chk("pack_rd1_b", 32'(ib.res_data1), 225);
        tick(4);

        // same pair, packing disabled
        pack_en = 1'b0; v = 2'b11; #1;
        chk("blk_rdy0", 32'(ia.req_ready), 2'b01);
        tick; v = 2'b10; #1;
        chk("blk_rdy1", 32'(ia.req_ready), 2'b10);
        chk("blk_mode", 32'(ia.dsp_mode), 0);
        chk("blk_aa0", 32'(ia.dsp_aa), 7);
        tick; v = 2'b00;
        chk("blk_aa1", 32'(ia.dsp_aa), 15);
        tick;
        chk("blk_rv0", 32'(ia.res_valid), 2'b01);
        chk("blk_rd0", 32'(ia.res_data0), 63);
        tick;
        chk("blk_rv1", 32'(ia.res_valid), 2'b10);
        chk("blk_rd1", 32'(ia.res_data1), 225);
        tick(6);

        // mixed width: no packing, strict alternation starting at 0
        pack_en = 1'b1; ra0 = 511; rb0 = 511; ra1 = 3; rb1 = 2; v = 2'b11;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("mix_rdy", 32'(ia.req_ready), (i % 2) ? 32'd2 : 32'd1);
            tick;
        end
        v = 2'b00;
        tick(10);
        chk("mix_rd0_a", 32'(ia.res_data0), 261121);
        chk("mix_rd1_a", 32'(ia.res_data1), 6);
        chk("mix_rd0_b", 32'(ib.res_data0), 261121);
        chk("mix_rd1_b", 32'(ib.res_data1), 6);

        // back-to-back random traffic, requests held until accepted
        g = 2'b00;
        for (int c = 0; c < 400 && n_ops < 50; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (!v[i] || g[i]) begin
                    v[i] = ($urandom_range(0, 3) != 0);
                    if ($urandom_range(0, 1) == 1) begin
                        if (i == 0) begin ra0 = 9'($urandom_range(0, 15));  rb0 = 9'($urandom_range(0, 15));  end
                        else        begin ra1 = 9'($urandom_range(0, 15));  rb1 = 9'($urandom_range(0, 15));  end
                    end else begin
                        if (i == 0) begin ra0 = 9'($urandom_range(0, 511)); rb0 = 9'($urandom_range(0, 511)); end
                        else        begin ra1 = 9'($urandom_range(0, 511)); rb1 = 9'($urandom_range(0, 511)); end
                    end
                end
            end
            pack_en = 1'($urandom_range(0, 1));
            #1;
            g = v & ia.req_ready;
            n_ops += $countones(g);
            tick;
        end
        v = 2'b00;
        chk("b2b_ops", 32'(n_ops >= 50), 1);
        tick(10);
        chk("b2b_cnt_a", got_cnt[0], exp_cnt[0]);
        chk("b2b_cnt_b", got_cnt[1], exp_cnt[1]);

        // reset with operations in flight
        pack_en = 1'b0;
        v = 2'b01; ra0 = 20; rb0 = 30;
        tick; v = 2'b10; ra1 = 40; rb1 = 50;
        tick; v = 2'b01; ra0 = 60; rb0 = 70;
        tick; v = 2'b00; rst_n = 1'b0; #1;
        chk("rstm_start", 32'(ib.dsp_start), 0);
        chk("rstm_aa", 32'(ib.dsp_aa), 0);
        tick; rst_n = 1'b1;
        tick(10);
        ra0 = 100; rb0 = 100; ra1 = 200; rb1 = 200; v = 2'b11; #1;
        chk("rstm_rr", 32'(ia.req_ready), 2'b01);
        tick; v = 2'b00;
        tick(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
